// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one serial-opcode ALU between two requesters,
// with a watchdog that turns a silent ALU into an error response.
module alu_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_overflow,
  output logic             resp_err,
  output logic             busy,
  output logic             opcode_valid,
  output logic             opcode,
  output logic [WIDTH-1:0] data,
  input  logic             done,
  input  logic             overflow,
  input  logic [WIDTH-1:0] result
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND0 = 3'd1;
  localparam logic [2:0] S_SEND1 = 3'd2;
  localparam logic [2:0] S_SEND2 = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             id_q, id_d;
  logic [7:0]       wdog_q, wdog_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d, err_q, err_d;
  logic             gnt_any, gnt_id, idle;

  // With both valid the requester that did not win last time is served.
  assign gnt_any = req0_valid | req1_valid;
  assign gnt_id  = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  // Gated by reset_n so the ready outputs read 0 while reset is held.
  assign idle    = (state_q == S_IDLE) & reset_n;

  assign req0_ready    = idle & gnt_any & ~gnt_id;
  assign req1_ready    = idle & gnt_any & gnt_id;
  assign busy          = (state_q != S_IDLE);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_id       = id_q;
  assign resp_result   = res_q;
  assign resp_overflow = ovf_q;
  assign resp_err      = err_q;

  always_comb begin
    opcode_valid = 1'b0;
    opcode       = 1'b0;
    data         = '0;
    case (state_q)
      S_SEND0: begin opcode_valid = 1'b1; opcode = op_q[0]; data = a_q; end
      S_SEND1: begin opcode_valid = 1'b1; opcode = op_q[1]; data = b_q; end
      S_SEND2: begin opcode_valid = 1'b1; opcode = op_q[2]; end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    wdog_d       = wdog_q;
    res_d        = res_q;
    ovf_d        = ovf_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: if (gnt_any) begin
        op_d         = gnt_id ? req1_op : req0_op;
        a_d          = gnt_id ? req1_a  : req0_a;
        b_d          = gnt_id ? req1_b  : req0_b;
        id_d         = gnt_id;
        last_grant_d = gnt_id;
        state_d      = S_SEND0;
      end
      S_SEND0: state_d = S_SEND1;
      S_SEND1: state_d = S_SEND2;
      S_SEND2: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 8'd1;
        // done wins over a timeout landing in the same cycle
        if (done) begin
          res_d   = result;
          ovf_d   = overflow;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wdog_q == WDOG_LAST) begin
          res_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      wdog_q       <= '0;
      res_q        <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      wdog_q       <= wdog_d;
      res_q        <= res_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: the bench plays both requesters and the ALU.
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       resp_valid, resp_ready, resp_id, resp_overflow, resp_err, busy;
  logic [7:0] resp_result;
  logic       opcode_valid, opcode, done, overflow;
  logic [7:0] data, result;
  int         errors = 0, checks = 0;
  int         r0_cnt = 0, r1_cnt = 0, resp_cnt = 0;
  int         base0, base1, base_r;

  alu_arbiter #(.WIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
    .resp_overflow(resp_overflow), .resp_err(resp_err), .busy(busy),
    .opcode_valid(opcode_valid), .opcode(opcode), .data(data),
    .done(done), .overflow(overflow), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (req0_ready) r0_cnt <= r0_cnt + 1;
    if (req1_ready) r1_cnt <= r1_cnt + 1;
    if (resp_valid && resp_ready) resp_cnt <= resp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of SEND0; returns at the negedge of the RESP cycle.
  task automatic alu_cycle(input logic [7:0] r, input logic o);
    repeat (3) @(negedge clk);
    done = 1'b1; result = r; overflow = o;
    @(negedge clk);
    done = 1'b0; result = 8'h00; overflow = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; resp_ready = 1'b1; done = 1'b0; overflow = 1'b0; result = 8'h00;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'h00; req0_b = 8'h00;
    req1_valid = 1'b0; req1_op = 3'd0; req1_a = 8'h00; req1_b = 8'h00;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_opcode_valid", 32'(opcode_valid), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_ready0", 32'(req0_ready), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1; req0_valid = 1'b0;
    @(negedge clk);

    // single request, done on first WAIT cycle
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 8'h12; req0_b = 8'h34;
    #1 chk("single_ready0", 32'(req0_ready), 1);
    chk("single_ready1", 32'(req1_ready), 0);
    @(negedge clk); req0_valid = 1'b0;
    chk("send0_ov", 32'(opcode_valid), 1);
    chk("send0_op", 32'(opcode), 1);
    chk("send0_data", 32'(data), 32'h12);
    chk("send0_busy", 32'(busy), 1);
    @(negedge clk);
    chk("send1_op", 32'(opcode), 0);
    chk("send1_data", 32'(data), 32'h34);
    @(negedge clk);
    chk("send2_ov", 32'(opcode_valid), 1);
    chk("send2_op", 32'(opcode), 0);
    chk("send2_data", 32'(data), 0);
    @(negedge clk);
    chk("wait_ov", 32'(opcode_valid), 0);
    chk("wait_resp_valid", 32'(resp_valid), 0);
    done = 1'b1; result = 8'h46; overflow = 1'b0;
    @(negedge clk); done = 1'b0;
    chk("single_resp_valid", 32'(resp_valid), 1);
    chk("single_id", 32'(resp_id), 0);
    chk("single_result", 32'(resp_result), 32'h46);
    chk("single_err", 32'(resp_err), 0);
    chk("single_ovf", 32'(resp_overflow), 0);
    @(negedge clk);
    chk("single_after_valid", 32'(resp_valid), 0);
    chk("single_after_busy", 32'(busy), 0);

    // overflow, issued from requester 1
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 8'hF0; req1_b = 8'h20;
    #1 chk("ovf_ready1", 32'(req1_ready), 1);
    @(negedge clk); req1_valid = 1'b0;
    alu_cycle(8'h10, 1'b1);
    chk("ovf_valid", 32'(resp_valid), 1);
    chk("ovf_id", 32'(resp_id), 1);
    chk("ovf_result", 32'(resp_result), 32'h10);
    chk("ovf_flag", 32'(resp_overflow), 1);
    @(negedge clk);

    // round-robin with both requesters continuously valid
    base0 = r0_cnt; base1 = r1_cnt;
    req0_valid = 1'b1; req0_op = 3'd2; req1_valid = 1'b1; req1_op = 3'd3;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_ready0", 32'(req0_ready), (i % 2 == 0) ? 1 : 0);
      chk("rr_ready1", 32'(req1_ready), (i % 2 == 1) ? 1 : 0);
      @(negedge clk);
      chk("rr_no_ready_busy", 32'(req0_ready | req1_ready), 0);
      alu_cycle(8'(i + 8'h20), 1'b0);
      chk("rr_id", 32'(resp_id), i % 2);
      chk("rr_result", 32'(resp_result), 32'(i + 32'h20));
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1 chk("rr_cnt0", 32'(r0_cnt - base0), 2);
    chk("rr_cnt1", 32'(r1_cnt - base1), 2);

    // watchdog timeout
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'd4;
    #1 chk("to_ready0", 32'(req0_ready), 1);
    @(negedge clk); req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    repeat (16) @(negedge clk);
    chk("to_last_wait_valid", 32'(resp_valid), 0);
    chk("to_last_wait_busy", 32'(busy), 1);
    @(negedge clk);
    chk("to_valid", 32'(resp_valid), 1);
    chk("to_err", 32'(resp_err), 1);
    chk("to_result", 32'(resp_result), 0);
    chk("to_ovf", 32'(resp_overflow), 0);
    @(negedge clk);
    chk("to_idle", 32'(busy), 0);
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 8'h01; req1_b = 8'h02;
    #1 chk("to_next_ready1", 32'(req1_ready), 1);
    @(negedge clk); req1_valid = 1'b0;
    alu_cycle(8'h55, 1'b0);
    chk("to_next_err", 32'(resp_err), 0);
    chk("to_next_result", 32'(resp_result), 32'h55);
    @(negedge clk);

    // backpressure with stray done pulses during RESP
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd5; req0_a = 8'h03; req0_b = 8'h04;
    #1 chk("bp_ready0", 32'(req0_ready), 1);
    @(negedge clk); req0_valid = 1'b0;
    alu_cycle(8'hA5, 1'b1);
    base_r = resp_cnt; base1 = r1_cnt;
    req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(resp_valid), 1);
      chk("bp_result", 32'(resp_result), 32'hA5);
      chk("bp_ovf", 32'(resp_overflow), 1);
      chk("bp_id", 32'(resp_id), 0);
      chk("bp_ready1", 32'(req1_ready), 0);
      done = (i == 2 || i == 5); result = 8'hFF; overflow = 1'b0;
      @(negedge clk);
    end
    done = 1'b0; result = 8'h00;
    chk("bp_no_grant", 32'(r1_cnt - base1), 0);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_drop_valid", 32'(resp_valid), 0);
    chk("bp_one_resp", 32'(resp_cnt - base_r), 1);
    #1 chk("bp_then_ready1", 32'(req1_ready), 1);
    @(negedge clk); req1_valid = 1'b0;
    alu_cycle(8'h77, 1'b0);
    chk("bp_next_id", 32'(resp_id), 1);
    chk("bp_next_result", 32'(resp_result), 32'h77);
    @(negedge clk);

    // reset while in WAIT
    req0_valid = 1'b1;
    @(negedge clk); req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rw_busy_wait", 32'(busy), 1);
    base_r = resp_cnt;
    #2 reset_n = 1'b0;
    #1 chk("rw_busy", 32'(busy), 0);
    chk("rw_valid", 32'(resp_valid), 0);
    chk("rw_ov", 32'(opcode_valid), 0);
    @(negedge clk);
    reset_n = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1 chk("rw_ready0", 32'(req0_ready), 1);
    chk("rw_ready1", 32'(req1_ready), 0);
    chk("rw_no_resp", 32'(resp_cnt - base_r), 0);
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
    alu_cycle(8'h99, 1'b0);
    chk("rw_id", 32'(resp_id), 0);
    chk("rw_result", 32'(resp_result), 32'h99);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one simple_alu instance between two requesters.
- Round-robin arbitration between the requesters.
- Serializes the granted command onto the ALU's serial opcode/data bus, waits for done, and returns result and overflow on a shared response channel tagged with the requester id.
- A watchdog flags ALUs that never respond.
- Sits between the requester logic and the simple_alu, in place of the stimulus driver used in the ALU bench.

Parameters:
- WIDTH, 8, operand/result width; matches the ALU data bus.
- TIMEOUT, 16, max WAIT cycles before the command is aborted with error; legal range 2..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a command.
- req0_op  input  3  requester 0 opcode.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req1_valid, req1_op, req1_a, req1_b, req1_ready: same as requester 0.
- resp_valid  output  1  response available.
- resp_ready  input  1  response consumer accepts.
- resp_id  output  1  requester that owns the response.
- resp_result  output  WIDTH  ALU result.
- resp_overflow  output  1  ALU overflow flag.
- resp_err  output  1  command timed out.
- busy  output  1  FSM not in IDLE.
- opcode_valid  output  1  to ALU: opcode/data phase active.
- opcode  output  1  to ALU: serial opcode bit.
- data  output  WIDTH  to ALU: operand bus.
- done  input  1  from ALU: result valid.
- overflow  input  1  from ALU: overflow, qualified by done.
- result  input  WIDTH  from ALU: result, qualified by done.

Behaviour:
- Reset (async, any state): FSM goes to IDLE. All outputs are 0. last_grant is 1, so requester 0 wins first. Watchdog is 0. Latched command is 0.
- An in-flight command is dropped by reset; no response is produced for it.
- The ALU's own reset_n is driven externally, not by this block.
- States: IDLE, SEND0, SEND1, SEND2, WAIT, RESP.
- IDLE:
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester not equal to last_grant is granted.
  - reqN_ready is combinational and high only in IDLE for the granted requester.
  - On that edge: latch op/a/b/id, update last_grant, go to SEND0.
  - Requesters must hold their fields stable while valid and not ready.
- ALU issue (one cycle per state, opcode_valid=1, op sent LSB first):
  - SEND0: opcode=op[0], data=A.
  - SEND1: opcode=op[1], data=B.
  - SEND2: opcode=op[2], data=0.
- Outside SEND0..SEND2: opcode_valid=0, opcode=0, data=0.
- WAIT:
  - Watchdog increments each cycle from 0.
  - If done=1 is sampled: capture result and overflow, resp_err=0, go to RESP.
  - Else, when the watchdog reaches TIMEOUT-1: resp_result=0, resp_overflow=0, resp_err=1, go to RESP.
  - done takes priority over timeout in the same cycle.
- RESP:
  - resp_valid=1, with resp_id/result/overflow/err held stable.
  - When resp_ready=1: go to IDLE; resp_valid drops next cycle.
  - No new grant occurs in the RESP cycle.
  - Minimum request-to-request spacing is 6 cycles.
- done asserted outside WAIT is ignored; it has no effect on state or outputs.
- Minimum latency: ready at cycle T. SEND0..SEND2 occupy T+1..T+3. done is earliest at T+4. resp_valid is earliest at T+5.
- busy = (state != IDLE).

Test Plan:
- Single request: req0 op=3'b001, A=8'h12, B=8'h34; ALU returns done at first WAIT cycle with result=8'h46, overflow=0.
  - Expect opcode bits 1,0,0 on T+1..T+3, with data 12,34,00.
  - Expect resp_valid at T+5 with id=0, result=46, err=0.
- Round-robin: both requesters continuously valid for 4 commands.
  - Grant order is 0,1,0,1.
  - Each reqN_ready pulses exactly once per grant, only in IDLE.
- Overflow: op=add, A=8'hF0, B=8'h20; ALU returns result=8'h10, overflow=1.
  - Expect resp_overflow=1, resp_result=10.
- Timeout: ALU never asserts done.
  - Expect resp_valid after exactly TIMEOUT WAIT cycles (16), with err=1, result=0, overflow=0.
  - Next command is then accepted normally.
- Backpressure and stray done:
  - Hold resp_ready=0 for 10 cycles while pulsing done twice.
  - Response fields must be stable throughout; no extra response; no grant until resp_ready=1.
- Reset mid-WAIT: drop reset_n for one cycle while in WAIT.
  - Outputs go to 0 immediately (asynchronously).
  - No response is issued.
  - After release, req1 and req0 both valid: req0 is granted first.
